// File: rtl/ones_pattern_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ones_pattern_gen
// Description : Inverse of a population counter. Accepts a ones-count on din
//               and builds a DATA_WIDTH word holding exactly min(din,
//               DATA_WIDTH) one bits as a single contiguous run. The word is
//               assembled bit-serially (one bit per cycle, DATA_WIDTH cycles)
//               and presented with a valid/ready handshake.
//
// Parameters  : DATA_WIDTH  output word width (>= 2); count width is
//                           $clog2(DATA_WIDTH)+1
//
// Ports       : clk         in   clock, rising edge
//               resetn      in   asynchronous active-low reset
//               din         in   requested number of one bits
//               din_valid   in   din is valid
//               din_ready   out  block can accept din (IDLE only)
//               dout        out  generated word (0 unless dout_valid)
//               dout_valid  out  dout/sat are valid (HOLD only)
//               dout_ready  in   consumer accepts dout
//               sat         out  din exceeded DATA_WIDTH and was clamped
//
// Build option: ONES_PATTERN_ROTATE_EN
//               defined   - the start bit of each run advances by one
//                           (mod DATA_WIDTH) after every delivered word, and
//                           runs wrap past the MSB into bit 0.
//               undefined - start bit is always 0, giving an LSB-aligned
//                           thermometer code dout = (1<<n)-1.
//
// Revision    : 1.0  initial release
// ============================================================================
module ones_pattern_gen #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [$clog2(DATA_WIDTH):0]   din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          sat
);

  localparam int c_IDX_W = $clog2(DATA_WIDTH);
  localparam int c_CNT_W = c_IDX_W + 1;

  // DATA_WIDTH expressed at count width, used for clamping and position wrap
  localparam logic [c_CNT_W-1:0] c_DW_CNT   = c_CNT_W'(DATA_WIDTH);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_WIDTH - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUILD = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                  state_q,   state_d;
  logic [DATA_WIDTH-1:0]   word_q,    word_d;
  logic [c_CNT_W-1:0]      n_q,       n_d;
  logic                    sat_q,     sat_d;
  logic [c_IDX_W-1:0]      off_q,     off_d;
  logic [c_IDX_W-1:0]      idx_q,     idx_d;
  logic [c_IDX_W-1:0]      rot_ptr_q, rot_ptr_d;

  logic                    w_accept;
  logic                    w_deliver;
  logic [c_CNT_W-1:0]      w_pos_sum;
  logic [c_CNT_W-1:0]      w_pos_wrap;
  logic [c_IDX_W-1:0]      w_pos;
  logic                    w_bit;

  assign w_accept  = (state_q == S_IDLE) && din_valid;
  assign w_deliver = (state_q == S_HOLD) && dout_ready;

  // Bit position (off + idx) mod DATA_WIDTH. Both operands are below
  // DATA_WIDTH, so a single conditional subtract is a full modulo and also
  // covers widths that are not a power of two.
  assign w_pos_sum  = {1'b0, off_q} + {1'b0, idx_q};
  assign w_pos_wrap = (w_pos_sum >= c_DW_CNT) ? (w_pos_sum - c_DW_CNT) : w_pos_sum;
  assign w_pos      = w_pos_wrap[c_IDX_W-1:0];

  // The first n positions of the run are ones, the remainder zeros
  assign w_bit = ({1'b0, idx_q} < n_q);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      word_q    <= '0;
      n_q       <= '0;
      sat_q     <= 1'b0;
      off_q     <= '0;
      idx_q     <= '0;
      rot_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      n_q       <= n_d;
      sat_q     <= sat_d;
      off_q     <= off_d;
      idx_q     <= idx_d;
      rot_ptr_q <= rot_ptr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    n_d       = n_q;
    sat_d     = sat_q;
    off_d     = off_q;
    idx_d     = idx_q;
    rot_ptr_d = rot_ptr_q;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          // Saturation is decided on the unclamped request
          sat_d   = (din > c_DW_CNT);
          n_d     = (din > c_DW_CNT) ? c_DW_CNT : din;
          off_d   = rot_ptr_q;
          idx_d   = '0;
          // Every bit is rewritten during BUILD; clearing keeps the
          // contents deterministic should a build ever be cut short.
          word_d  = '0;
          state_d = S_BUILD;
        end
      end

      S_BUILD: begin
        word_d[w_pos] = w_bit;
        if (idx_q == c_LAST_IDX) begin
          idx_d   = '0;
          state_d = S_HOLD;
        end else begin
          idx_d   = idx_q + c_IDX_ONE;
        end
      end

      S_HOLD: begin
        if (w_deliver) begin
          state_d = S_IDLE;
`ifdef ONES_PATTERN_ROTATE_EN
          rot_ptr_d = (rot_ptr_q == c_LAST_IDX) ? '0 : (rot_ptr_q + c_IDX_ONE);
`else
          rot_ptr_d = '0;
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from registered state only. dout and sat are masked to
  // zero outside HOLD so a consumer never sees a partially built word.
  // --------------------------------------------------------------------------
  assign din_ready  = (state_q == S_IDLE);
  assign dout_valid = (state_q == S_HOLD);
  assign dout       = (state_q == S_HOLD) ? word_q : '0;
  assign sat        = (state_q == S_HOLD) ? sat_q  : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ones_pattern_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ones_pattern_gen
// Description : Self-checking bench for ones_pattern_gen (DATA_WIDTH = 16).
//               Expected words are pushed to a scoreboard queue when a
//               request is accepted and popped when the DUT offers its word.
//               Follows ONES_PATTERN_ROTATE_EN in the same way as the design.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ones_pattern_gen;

  localparam int DW = 16;
  localparam int CW = $clog2(DW) + 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic [CW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          sat;

  typedef struct packed {
    logic [DW-1:0] word;
    logic          sat;
  } exp_t;

  exp_t sb[$];
  int   n_vec     = 0;
  int   n_fail    = 0;
  int   model_rot = 0;

  always #5 clk = ~clk;

  ones_pattern_gen #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sat        (sat)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: a block of n ones at the LSB, rotated left by the model pointer
  function automatic exp_t model(input int d);
    exp_t            r;
    int              n;
    logic [DW-1:0]   base;
    logic [2*DW-1:0] dbl;
    n      = (d > DW) ? DW : d;
    base   = (n >= DW) ? '1 : DW'((32'd1 << n) - 32'd1);
    dbl    = {base, base} << model_rot;
    r.word = dbl[2*DW-1:DW];
    r.sat  = (d > DW);
    return r;
  endfunction

  // Drive one request, check latency, optionally stall in HOLD, then deliver.
  task automatic request(input int d, input int hold, input bit busy_pokes);
    exp_t          e;
    int            waitc;
    logic [DW-1:0] first_dout;
    logic          first_sat;
    @(negedge clk);
    din       = CW'(d);
    din_valid = 1'b1;
    waitc     = 0;
    while (din_ready !== 1'b1 && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check("accept_ready", 32'(din_ready), 32'd1);
    sb.push_back(model(d));
    @(posedge clk);                 // accept edge k
    @(negedge clk);                 // after edge k
    if (busy_pokes) din = CW'(d ^ 9);   // keep poking a different request
    else            din_valid = 1'b0;
    check("build_not_ready", 32'(din_ready), 32'd0);
    repeat (15) @(negedge clk);     // after edge k+15
    check("lat_early", 32'(dout_valid), 32'd0);
    @(negedge clk);                 // after edge k+16
    check("lat_valid", 32'(dout_valid), 32'd1);
    first_dout = dout;
    first_sat  = sat;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (busy_pokes) din_valid = ~din_valid;
      check("hold_dout",      32'(dout),       32'(first_dout));
      check("hold_sat",       32'(sat),        32'(first_sat));
      check("hold_not_ready", 32'(din_ready),  32'd0);
      check("hold_valid",     32'(dout_valid), 32'd1);
    end
    if (hold > 0) @(negedge clk);
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    check("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("dout", 32'(dout), 32'(e.word));
      check("sat",  32'(sat),  32'(e.sat));
    end
    @(posedge clk);                 // output handshake
    @(negedge clk);
    dout_ready = 1'b0;
`ifdef ONES_PATTERN_ROTATE_EN
    model_rot = (model_rot + 1) % DW;
`endif
    check("idle_ready",     32'(din_ready),  32'd1);
    check("idle_valid",     32'(dout_valid), 32'd0);
    check("idle_dout_mask", 32'(dout),       32'd0);
    check("idle_sat_mask",  32'(sat),        32'd0);
  endtask

  initial begin
    resetn     = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dout",   32'(dout),       32'd0);
    check("rst_valid",  32'(dout_valid), 32'd0);
    check("rst_sat",    32'(sat),        32'd0);
    check("rst_ready",  32'(din_ready),  32'd1);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_ready", 32'(din_ready),  32'd1);
    check("post_rst_valid", 32'(dout_valid), 32'd0);

    // Three identical requests: walking run when rotation is enabled
    request(3, 0, 1'b0);
    request(3, 0, 1'b0);
    request(3, 0, 1'b0);

    // Thermometer patterns and boundaries
    request(5,  0, 1'b0);
    request(0,  0, 1'b0);
    request(20, 0, 1'b0);
    request(16, 0, 1'b0);

    // Back-pressure in HOLD with din_valid activity while busy
    request(7, 10, 1'b1);

    // dout_ready while idle has no effect
    @(negedge clk);
    dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_rdy_valid", 32'(dout_valid), 32'd0);
    check("idle_rdy_ready", 32'(din_ready),  32'd1);
    dout_ready = 1'b0;

    // Advance the pointer to 15, then the wrap-around run
    for (int i = 0; i < 7; i++) request(int'($urandom_range(0, 20)), 0, 1'b0);
    request(3, 0, 1'b0);

    // Reset in the middle of a build (idx == 7)
    @(negedge clk);
    din       = CW'(9);
    din_valid = 1'b1;
    @(posedge clk);                 // accept edge k (DUT idle here)
    @(negedge clk);
    din_valid = 1'b0;
    repeat (7) @(negedge clk);      // after edge k+7: idx == 7
    resetn = 1'b0;
    #1;
    check("midrst_dout",  32'(dout),       32'd0);
    check("midrst_valid", 32'(dout_valid), 32'd0);
    check("midrst_sat",   32'(sat),        32'd0);
    check("midrst_ready", 32'(din_ready),  32'd1);
    sb.delete();
    model_rot = 0;
    @(negedge clk);
    resetn = 1'b1;

    // Normal completion after the aborted build, pointer back at 0
    request(11, 0, 1'b0);
    request(2,  3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Absolute guard so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
